rr_lock_arbiter: RTL and testbench

RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

---
 rtl/rr_lock_arbiter_pkg.sv | 40 ++++
 rtl/rr_lock_arbiter_rr_priority_pick.sv | 31 +++
 rtl/rr_lock_arbiter.sv | 120 ++++++++++++
 tb/tb_rr_lock_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_lock_arbiter_pkg.sv
// rr_lock_arbiter_pkg
//   Shared types and helpers for the packet-locking round-robin arbiter.
//   - arb_state_e : arbiter FSM state (IDLE, LOCKED)
//   - rr_pick()   : round-robin search over up to MAX_N requesters
package rr_lock_arbiter_pkg;

    localparam int MAX_N = 16;
    localparam int PICK_W = 4;   // index width wide enough for MAX_N

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // First valid index at or above ptr, wrapping n-1 -> 0. Returns ptr
    // when nothing is valid, so the chosen index stays stable while idle.
    function automatic logic [PICK_W-1:0] rr_pick(
        input logic [MAX_N-1:0]  valid,
        input logic [PICK_W-1:0] ptr,
        input int                n
    );
        logic [PICK_W-1:0] idx;
        logic              found;
        int                j;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (!found && valid[j[PICK_W-1:0]]) begin
                    idx   = j[PICK_W-1:0];
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_lock_arbiter_rr_priority_pick.sv
// rr_priority_pick
//   Combinational round-robin priority search.
//   Ports:
//     valid [N-1:0]      : per-requester request
//     ptr   [IW-1:0]     : highest-priority index this cycle
//     idx   [IW-1:0]     : first valid index searching upward from ptr
//                          (equals ptr when nothing is valid)
//     any                : at least one requester is valid
module rr_priority_pick
    import rr_lock_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [MAX_N-1:0]  valid_ext;
    logic [PICK_W-1:0] ptr_ext;
    logic [PICK_W-1:0] pick;

    assign valid_ext = MAX_N'(valid);
    assign ptr_ext   = PICK_W'(ptr);
    assign pick      = rr_pick(valid_ext, ptr_ext, N);
    assign idx       = IW'(pick);
    assign any       = |valid;

endmodule

// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter
//   N-way round-robin arbiter that locks onto a requester for the whole of
//   a multi-beat packet. Grant is combinational (zero-cycle latency).
//   Ports:
//     clock, reset_n          : clock, asynchronous active-low reset
//     io_in_valid/ready [N]   : per-requester handshake
//     io_in_bits [N*W]        : requester i payload at [i*W +: W]
//     io_in_last [N]          : last beat of requester i's packet
//     io_out_valid/ready      : downstream handshake
//     io_out_bits [W]         : selected payload
//     io_out_last             : selected last flag
//     io_chosen [clog2(N)]    : granted requester index
//     io_busy                 : a packet currently holds the lock
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [N-1:0]          io_in_valid,
    output logic [N-1:0]          io_in_ready,
    input  logic [N*W-1:0]        io_in_bits,
    input  logic [N-1:0]          io_in_last,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [W-1:0]          io_out_bits,
    output logic                  io_out_last,
    output logic [$clog2(N)-1:0]  io_chosen,
    output logic                  io_busy
);

    localparam int IW = $clog2(N);

    arb_state_e    state, state_next;
    logic [IW-1:0] ptr, ptr_next;
    logic [IW-1:0] lock_idx, lock_idx_next;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [IW-1:0] grant;
    logic          xfer;

    rr_priority_pick #(.N(N), .IW(IW)) u_pick (
        .valid (io_in_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign grant = (state == LOCKED) ? lock_idx : pick_idx;

    // Output mux. Valid is masked by reset_n so nothing can appear to
    // transfer while the block is held in reset.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        io_out_valid = 1'b0;
        io_out_bits  = '0;
        io_out_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant == IW'(i)) begin
                io_out_valid = io_in_valid[i] & reset_n;
                io_out_bits  = io_in_bits[i*W +: W];
                io_out_last  = io_in_last[i];
            end
        end
    end

    always_comb begin
        io_in_ready = '0;
        for (int i = 0; i < N; i++) begin
            io_in_ready[i] = io_out_ready & io_out_valid & (grant == IW'(i));
        end
    end

    assign io_chosen = grant;
    assign io_busy   = (state == LOCKED);
    assign xfer      = io_out_valid & io_out_ready;

    // Next-state: lock on a non-last beat, release and advance ptr past the
    // owner on a last beat. A dropped valid while locked just stalls.
    always_comb begin
        state_next    = state;
        ptr_next      = ptr;
        lock_idx_next = lock_idx;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (io_out_last) begin
                        ptr_next = (grant == IW'(N-1)) ? '0 : grant + 1'b1;
                    end else begin
                        state_next    = LOCKED;
                        lock_idx_next = grant;
                    end
                end
            end
            LOCKED: begin
                if (xfer && io_out_last) begin
                    state_next = IDLE;
                    ptr_next   = (lock_idx == IW'(N-1)) ? '0 : lock_idx + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            lock_idx <= '0;
        end else begin
            // NOTE: non-blocking so all registers update from pre-edge values.
            state    <= state_next;
            ptr      <= ptr_next;
            lock_idx <= lock_idx_next;
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// tb_rr_lock_arbiter
//   Directed self-checking bench for rr_lock_arbiter (N=4, W=8).
module tb_rr_lock_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clock;
    logic           reset_n;
    logic [N-1:0]   io_in_valid;
    logic [N-1:0]   io_in_ready;
    logic [N*W-1:0] io_in_bits;
    logic [N-1:0]   io_in_last;
    logic           io_out_valid;
    logic           io_out_ready;
    logic [W-1:0]   io_out_bits;
    logic           io_out_last;
    logic [1:0]     io_chosen;
    logic           io_busy;

    int total = 0;
    int bad   = 0;

    rr_lock_arbiter #(.N(N), .W(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_bits   (io_in_bits),
        .io_in_last   (io_in_last),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_bits  (io_out_bits),
        .io_out_last  (io_out_last),
        .io_chosen    (io_chosen),
        .io_busy      (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Readies must be one-hot or zero on every cycle.
    always @(negedge clock) begin
        total++;
        if (!$onehot0(io_in_ready)) begin
            bad++;
            $display("FAIL onehot0_ready: got %b required one-hot or zero", io_in_ready);
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        io_in_valid  = 4'b1111;
        io_in_last   = 4'b1111;
        io_in_bits   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        io_out_ready = 1'b1;
        tick();
        tick();
        total++;
        if (io_out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b required 0", io_out_valid);
        end
        total++;
        if (io_in_ready !== 4'b0000) begin
            bad++; $display("FAIL reset_in_ready: got %b required 0000", io_in_ready);
        end
        total++;
        if (io_busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b required 0", io_busy);
        end
    endtask

    // All four valid with last=1: one single-beat packet per cycle, 0,1,2,3,0.
    task automatic test_round_robin();
        logic [1:0] exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (io_chosen !== exp_idx[k] || io_in_ready !== (4'b0001 << exp_idx[k])) begin
                bad++;
                $display("FAIL rr_seq[%0d]: got chosen=%0d ready=%b required chosen=%0d ready=%b",
                         k, io_chosen, io_in_ready, exp_idx[k], 4'b0001 << exp_idx[k]);
            end
            total++;
            if (io_out_bits !== (8'hA0 + 8'(exp_idx[k])) || io_out_last !== 1'b1) begin
                bad++;
                $display("FAIL rr_bits[%0d]: got bits=%h last=%b required bits=%h last=1",
                         k, io_out_bits, io_out_last, 8'hA0 + 8'(exp_idx[k]));
            end
            if (k < 4) tick();
        end
        // Transfer from 0 happens at the next edge, leaving ptr=1.
    endtask

    // ptr=1: requester 1 sends 3 beats while requester 2 waits.
    task automatic test_lock_packet();
        tick();
        io_in_valid = 4'b0110;
        io_in_last  = 4'b0100;
        for (int b = 0; b < 3; b++) begin
            if (b == 2) io_in_last = 4'b0110;
            #1;
            total++;
            if (io_chosen !== 2'd1 || io_in_ready !== 4'b0010) begin
                bad++;
                $display("FAIL lock_beat[%0d]: got chosen=%0d ready=%b required chosen=1 ready=0010",
                         b, io_chosen, io_in_ready);
            end
            total++;
            if (io_busy !== (b != 0)) begin
                bad++;
                $display("FAIL lock_busy[%0d]: got %b required %b", b, io_busy, b != 0);
            end
            tick();
        end
        #1;
        total++;
        if (io_busy !== 1'b0 || io_chosen !== 2'd2) begin
            bad++;
            $display("FAIL lock_release: got busy=%b chosen=%0d required busy=0 chosen=2",
                     io_busy, io_chosen);
        end
        io_in_valid = 4'b0000;   // withdraw 2 before the edge; ptr stays 2
    endtask

    // Lock on 1, then 1 drops valid for 2 cycles while 0 is valid.
    task automatic test_lock_drop_valid();
        tick();
        io_in_valid = 4'b0010;
        io_in_last  = 4'b0000;
        tick();
        io_in_valid = 4'b0001;
        io_in_last  = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (io_out_valid !== 1'b0 || io_in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL drop_stall[%0d]: got valid=%b ready=%b required valid=0 ready=0000",
                         c, io_out_valid, io_in_ready);
            end
            total++;
            if (io_chosen !== 2'd1 || io_busy !== 1'b1) begin
                bad++;
                $display("FAIL drop_hold[%0d]: got chosen=%0d busy=%b required chosen=1 busy=1",
                         c, io_chosen, io_busy);
            end
            tick();
        end
        // Finish the packet; ptr -> 2. Then a single beat from 3 sets ptr -> 0.
        io_in_valid = 4'b0011;
        io_in_last  = 4'b0011;
        #1;
        total++;
        if (io_in_ready !== 4'b0010) begin
            bad++;
            $display("FAIL drop_resume: got ready=%b required 0010", io_in_ready);
        end
        tick();
        io_in_valid = 4'b1000;
        io_in_last  = 4'b1000;
        #1;
        total++;
        if (io_chosen !== 2'd3) begin
            bad++;
            $display("FAIL drop_ptr: got chosen=%0d required 3", io_chosen);
        end
    endtask

    // ptr=0: downstream stalls 5 cycles with 0 and 3 valid.
    task automatic test_backpressure();
        tick();
        io_in_valid  = 4'b1001;
        io_in_last   = 4'b1001;
        io_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (io_chosen !== 2'd0 || io_in_ready !== 4'b0000 || io_out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_stall[%0d]: got chosen=%0d ready=%b valid=%b required 0 0000 1",
                         c, io_chosen, io_in_ready, io_out_valid);
            end
            tick();
        end
        io_out_ready = 1'b1;
        #1;
        total++;
        if (io_chosen !== 2'd0 || io_in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL bp_first: got chosen=%0d ready=%b required chosen=0 ready=0001",
                     io_chosen, io_in_ready);
        end
        tick();
        #1;
        total++;
        if (io_chosen !== 2'd3) begin
            bad++;
            $display("FAIL bp_second: got chosen=%0d required 3", io_chosen);
        end
    endtask

    // ptr=1 now: lock on 2, reset during beat 2, then check restart from 0.
    task automatic test_reset_mid_packet();
        io_in_valid = 4'b0100;
        io_in_last  = 4'b0000;
        tick();
        #1;
        total++;
        if (io_busy !== 1'b1 || io_chosen !== 2'd2) begin
            bad++;
            $display("FAIL mid_locked: got busy=%b chosen=%0d required busy=1 chosen=2",
                     io_busy, io_chosen);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (io_busy !== 1'b0 || io_in_ready !== 4'b0000 || io_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got busy=%b ready=%b valid=%b required 0 0000 0",
                     io_busy, io_in_ready, io_out_valid);
        end
        tick();
        io_in_valid = 4'b0110;
        io_in_last  = 4'b0110;
        reset_n     = 1'b1;
        #1;
        total++;
        if (io_chosen !== 2'd1 || io_busy !== 1'b0 || io_in_ready !== 4'b0010) begin
            bad++;
            $display("FAIL mid_restart: got chosen=%0d busy=%b ready=%b required 1 0 0010",
                     io_chosen, io_busy, io_in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock_packet();
        test_lock_drop_valid();
        test_backpressure();
        test_reset_mid_packet();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
